mul4u_err_monitor: RTL and testbench

//  Downstream characterisation stage for the 4x4 unsigned approximate multipliers.

---
 rtl/mul4u_pkg.sv | 29 ++
 rtl/mul4u_err_dp.sv | 92 +++++++++
 rtl/mul4u_err_monitor.sv | 164 ++++++++++++++++
 tb/tb_mul4u_err_monitor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4u_pkg.sv
// ============================================================================
// Module      : mul4u_pkg
// Description : Shared widths, FSM state type and |diff| helper for mul4u blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul4u_pkg;

    localparam int W_OP = 4;
    localparam int W_P  = 2 * W_OP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Magnitude of a product difference; always fits in W_P bits.
    function automatic logic [W_P-1:0] abs_diff(input logic signed [W_P:0] diff);
        logic [W_P:0] mag;
        mag = diff[W_P] ? -diff : diff;
        return mag[W_P-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul4u_err_dp.sv
// ============================================================================
// Module      : mul4u_err_dp
// Description : Two-stage datapath: S1 registers operands and exact product,
//               S2 registers signed diff, |diff| and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul4u_err_dp
    import mul4u_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_i,
    input  logic [W_OP-1:0]       a_i,
    input  logic [W_OP-1:0]       b_i,
    input  logic [W_P-1:0]        p_i,
    output logic                  vld_o,
    output logic [W_OP-1:0]       a_o,
    output logic [W_OP-1:0]       b_o,
    output logic signed [W_P:0]   diff_o,
    output logic [W_P-1:0]        ed_o,
    output logic                  err_o,
    output logic                  empty_o
);

    logic                 s1_vld_q;
    logic [W_OP-1:0]      s1_a_q;
    logic [W_OP-1:0]      s1_b_q;
    logic [W_P-1:0]       s1_p_q;
    logic [W_P-1:0]       s1_exact_q;

    logic                 s2_vld_q;
    logic [W_OP-1:0]      s2_a_q;
    logic [W_OP-1:0]      s2_b_q;
    logic signed [W_P:0]  s2_diff_q;
    logic [W_P-1:0]       s2_ed_q;
    logic                 s2_err_q;

    logic signed [W_P:0]  w_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_p_q     <= '0;
            s1_exact_q <= '0;
        end else begin
            s1_vld_q <= vld_i;
            if (vld_i) begin
                s1_a_q     <= a_i;
                s1_b_q     <= b_i;
                s1_p_q     <= p_i;
                s1_exact_q <= W_P'(a_i) * W_P'(b_i);
            end
        end
    end

    assign w_diff = $signed({1'b0, s1_p_q}) - $signed({1'b0, s1_exact_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
            s2_diff_q <= '0;
            s2_ed_q   <= '0;
            s2_err_q  <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_a_q    <= s1_a_q;
                s2_b_q    <= s1_b_q;
                s2_diff_q <= w_diff;
                s2_ed_q   <= abs_diff(w_diff);
                s2_err_q  <= (w_diff != '0);
            end
        end
    end

    assign vld_o   = s2_vld_q;
    assign a_o     = s2_a_q;
    assign b_o     = s2_b_q;
    assign diff_o  = s2_diff_q;
    assign ed_o    = s2_ed_q;
    assign err_o   = s2_err_q;
    assign empty_o = !s1_vld_q && !s2_vld_q;

endmodule

`default_nettype wire

// File: rtl/mul4u_err_monitor.sv
// ============================================================================
// Module      : mul4u_err_monitor
// Description : Windowed error-metric accumulator for 4x4 approximate multipliers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul4u_err_monitor
    import mul4u_pkg::*;
#(
    parameter int N_LOG = 8,
    parameter int SUM_W = W_P + N_LOG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [W_OP-1:0]    in_a_i,
    input  logic [W_OP-1:0]    in_b_i,
    input  logic [W_P-1:0]     in_p_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [N_LOG:0]     err_cnt_o,
    output logic [SUM_W-1:0]   ed_sum_o,
    output logic [SUM_W:0]     bias_sum_o,
    output logic [W_P-1:0]     ed_max_o,
    output logic [W_OP-1:0]    max_a_o,
    output logic [W_OP-1:0]    max_b_o
);

    localparam logic [N_LOG:0] c_WIN  = (N_LOG+1)'(1) << N_LOG;
    localparam logic [N_LOG:0] c_LAST = c_WIN - (N_LOG+1)'(1);

    state_t              state_q, state_d;
    logic [N_LOG:0]      cnt_q, cnt_d;
    logic [N_LOG:0]      err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]    ed_sum_q, ed_sum_d;
    logic [SUM_W:0]      bias_sum_q, bias_sum_d;
    logic [W_P-1:0]      ed_max_q, ed_max_d;
    logic [W_OP-1:0]     max_a_q, max_a_d;
    logic [W_OP-1:0]     max_b_q, max_b_d;
    logic                arm_q;

    logic                w_xfer;
    logic                dp_vld;
    logic [W_OP-1:0]     dp_a;
    logic [W_OP-1:0]     dp_b;
    logic signed [W_P:0] dp_diff;
    logic [W_P-1:0]      dp_ed;
    logic                dp_err;
    logic                dp_empty;

    assign in_ready_o = (state_q == ST_RUN) && (cnt_q < c_WIN);
    assign w_xfer     = in_valid_i && in_ready_o;

    mul4u_err_dp u_dp (
        .clk     (clk),
        .rst     (rst),
        .vld_i   (w_xfer),
        .a_i     (in_a_i),
        .b_i     (in_b_i),
        .p_i     (in_p_i),
        .vld_o   (dp_vld),
        .a_o     (dp_a),
        .b_o     (dp_b),
        .diff_o  (dp_diff),
        .ed_o    (dp_ed),
        .err_o   (dp_err),
        .empty_o (dp_empty)
    );

    // Blocks a start that coincides with the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) arm_q <= 1'b0;
        else     arm_q <= 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;
        ed_sum_d   = ed_sum_q;
        bias_sum_d = bias_sum_q;
        ed_max_d   = ed_max_q;
        max_a_d    = max_a_q;
        max_b_d    = max_b_q;

        if (dp_vld) begin
            err_cnt_d  = err_cnt_q + (N_LOG+1)'(dp_err);
            ed_sum_d   = ed_sum_q + SUM_W'(dp_ed);
            bias_sum_d = bias_sum_q + {{(SUM_W-W_P){dp_diff[W_P]}}, dp_diff};
            if (dp_ed > ed_max_q) begin
                ed_max_d = dp_ed;
                max_a_d  = dp_a;
                max_b_d  = dp_b;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && arm_q) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    err_cnt_d  = '0;
                    ed_sum_d   = '0;
                    bias_sum_d = '0;
                    ed_max_d   = '0;
                    max_a_d    = '0;
                    max_b_d    = '0;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    cnt_d = cnt_q + (N_LOG+1)'(1);
                    if (cnt_q == c_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dp_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
            ed_sum_q   <= '0;
            bias_sum_q <= '0;
            ed_max_q   <= '0;
            max_a_q    <= '0;
            max_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
            ed_sum_q   <= ed_sum_d;
            bias_sum_q <= bias_sum_d;
            ed_max_q   <= ed_max_d;
            max_a_q    <= max_a_d;
            max_b_q    <= max_b_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign err_cnt_o  = err_cnt_q;
    assign ed_sum_o   = ed_sum_q;
    assign bias_sum_o = bias_sum_q;
    assign ed_max_o   = ed_max_q;
    assign max_a_o    = max_a_q;
    assign max_b_o    = max_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mul4u_err_monitor.sv
// ============================================================================
// Module      : tb_mul4u_err_monitor
// Description : Randomized self-checking bench for mul4u_err_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul4u_err_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, in_valid_i = 1'b0;
    logic [3:0]  in_a_i = '0, in_b_i = '0;
    logic [7:0]  in_p_i = '0;
    logic        in_ready_o, busy_o, done_o;
    logic [8:0]  err_cnt_o;
    logic [15:0] ed_sum_o;
    logic [16:0] bias_sum_o;
    logic [7:0]  ed_max_o;
    logic [3:0]  max_a_o, max_b_o;

    // Small-window instance (N_LOG = 2)
    logic        s_start = 1'b0, s_valid = 1'b0;
    logic [3:0]  s_a = '0, s_b = '0;
    logic [7:0]  s_p = '0;
    logic        s_ready, s_busy, s_done;
    logic [2:0]  s_err_cnt;
    logic [9:0]  s_ed_sum;
    logic [10:0] s_bias_sum;
    logic [7:0]  s_ed_max;
    logic [3:0]  s_max_a, s_max_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_g   = 0;

    logic [3:0] sa [256];
    logic [3:0] sb [256];
    logic [7:0] sp [256];

    int      exp_err, exp_sum, exp_max, exp_ma, exp_mb;
    longint  exp_bias;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    mul4u_err_monitor u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i), .in_p_i(in_p_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .ed_sum_o(ed_sum_o),
        .bias_sum_o(bias_sum_o), .ed_max_o(ed_max_o), .max_a_o(max_a_o), .max_b_o(max_b_o)
    );

    mul4u_err_monitor #(.N_LOG(2)) u_dut_small (
        .clk(clk), .rst(rst), .start_i(s_start), .in_valid_i(s_valid),
        .in_ready_o(s_ready), .in_a_i(s_a), .in_b_i(s_b), .in_p_i(s_p),
        .busy_o(s_busy), .done_o(s_done), .err_cnt_o(s_err_cnt), .ed_sum_o(s_ed_sum),
        .bias_sum_o(s_bias_sum), .ed_max_o(s_ed_max), .max_a_o(s_max_a), .max_b_o(s_max_b)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_exact();
        for (int i = 0; i < 256; i++) begin
            sa[i] = 4'(i / 16);
            sb[i] = 4'(i % 16);
            sp[i] = 8'(sa[i] * sb[i]);
        end
    endtask

    // Reference: plain integer arithmetic over the intended window contents.
    task automatic model();
        int ex, d, ed;
        exp_err = 0; exp_sum = 0; exp_bias = 0; exp_max = 0; exp_ma = 0; exp_mb = 0;
        for (int i = 0; i < 256; i++) begin
            ex = int'(sa[i]) * int'(sb[i]);
            d  = int'(sp[i]) - ex;
            ed = (d < 0) ? -d : d;
            if (d != 0) exp_err++;
            exp_sum  += ed;
            exp_bias += d;
            if (ed > exp_max) begin
                exp_max = ed; exp_ma = int'(sa[i]); exp_mb = int'(sb[i]);
            end
        end
    endtask

    task automatic run_window(input string nm, input int gap_pct, input int abort_at,
                              input bit mid_start, input bit chk_first);
        int  idx, c0, clast, cd, cyc;
        bit  v, rdy, seen;
        longint bias;
        model();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({nm, "_busy_run"}, longint'(busy_o), 1);
        idx = 0; cyc = 0; c0 = 0; clast = 0;
        while (idx < 256 && cyc < 3000) begin
            v          = ($urandom_range(99) >= gap_pct);
            in_valid_i = v;
            in_a_i     = sa[idx];
            in_b_i     = sb[idx];
            in_p_i     = sp[idx];
            start_i    = mid_start && (idx == 10);
            rdy        = in_ready_o;
            @(posedge clk);
            #1;
            if (v && rdy) begin
                if (idx == 0) c0 = cyc_g;
                clast = cyc_g;
                idx++;
            end
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk({nm, "_rst_err"}, longint'(err_cnt_o), 0);
                chk({nm, "_rst_sum"}, longint'(ed_sum_o), 0);
                chk({nm, "_rst_max"}, longint'(ed_max_o), 0);
                chk({nm, "_rst_busy"}, longint'(busy_o), 0);
                chk({nm, "_rst_rdy"}, longint'(in_ready_o), 0);
                seen = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    if (done_o) seen = 1'b1;
                end
                chk({nm, "_rst_nodone"}, longint'(seen), 0);
                @(negedge clk);
                start_i = 1'b1;
                rst     = 1'b0;
                @(posedge clk); #1;
                chk({nm, "_start_at_release"}, longint'(busy_o), 0);
                @(negedge clk);
                start_i    = 1'b0;
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        chk({nm, "_transfers"}, idx, 256);
        chk({nm, "_rdy_low_after"}, longint'(in_ready_o), 0);
        cd = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_o) begin cd = cyc_g; break; end
        end
        in_valid_i = 1'b0;
        chk({nm, "_done_lat_last"}, cd - clast, 3);
        if (chk_first) chk({nm, "_done_lat_first"}, cd - c0, 258);
        bias = $signed(bias_sum_o);
        chk({nm, "_err_cnt"}, longint'(err_cnt_o), exp_err);
        chk({nm, "_ed_sum"}, longint'(ed_sum_o), exp_sum);
        chk({nm, "_bias"}, bias, exp_bias);
        chk({nm, "_ed_max"}, longint'(ed_max_o), exp_max);
        chk({nm, "_max_a"}, longint'(max_a_o), exp_ma);
        chk({nm, "_max_b"}, longint'(max_b_o), exp_mb);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, longint'(done_o), 0);
        chk({nm, "_held_sum"}, longint'(ed_sum_o), exp_sum);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        longint sb_bias;
        int ea, eb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", longint'(in_ready_o), 0);
        chk("reset_busy", longint'(busy_o), 0);
        chk("reset_done", longint'(done_o), 0);
        chk("reset_err", longint'(err_cnt_o), 0);
        chk("reset_max", longint'(ed_max_o), 0);
        @(negedge clk);
        rst = 1'b0;
        // in_valid with no run active must not start or transfer anything
        in_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid_busy", longint'(busy_o), 0);
        chk("idle_valid_rdy", longint'(in_ready_o), 0);
        in_valid_i = 1'b0;

        load_exact();
        run_window("exact", 0, -1, 1'b0, 1'b1);

        load_exact();
        sp[3*16+3]   = 8'd8;
        sp[15*16+15] = 8'd229;
        run_window("two_err", 0, -1, 1'b0, 1'b0);
        run_window("two_err_gaps", 50, -1, 1'b0, 1'b0);

        load_exact();
        sp[2*16+3] = 8'd10;
        sp[5*16+7] = 8'd31;
        run_window("tie", 30, -1, 1'b1, 1'b0);

        load_exact();
        for (int i = 0; i < 256; i++)
            if ($urandom_range(3) == 0) sp[i] = 8'($urandom_range(255));
        run_window("random", 25, -1, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) sp[i] = 8'($urandom_range(255));
        run_window("abort", 10, 100, 1'b0, 1'b0);
        load_exact();
        run_window("after_abort", 0, -1, 1'b0, 1'b1);

        // Small window: 4 samples, each off by +1
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        ea = -1; eb = -1;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_a = 4'($urandom_range(15));
            s_b = 4'($urandom_range(15));
            s_p = 8'(int'(s_a) * int'(s_b) + 1);
            if (ea < 0) begin ea = int'(s_a); eb = int'(s_b); end
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("small_rdy_low", longint'(s_ready), 0);
        s_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (s_done) break;
        end
        sb_bias = $signed(s_bias_sum);
        chk("small_done", longint'(s_done), 1);
        chk("small_err_cnt", longint'(s_err_cnt), 4);
        chk("small_ed_sum", longint'(s_ed_sum), 4);
        chk("small_bias", sb_bias, 4);
        chk("small_ed_max", longint'(s_ed_max), 1);
        chk("small_max_a", longint'(s_max_a), ea);
        chk("small_max_b", longint'(s_max_b), eb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
